// File: rtl/seg_digit_driver.sv
// Four-digit seven-segment driver fed by a one-hot digit rotator, with dead time on digit switches
// and frame-aligned value commits. Define SEG_LZ_BLANK_EN to enable leading-zero suppression.

module seg_hex7 (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  // Active-low {g,f,e,d,c,b,a}
  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      unique case (nib)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        4'hF: seg = 7'b0001110;
        default: seg = 7'b1111111;
      endcase
    end
  end
endmodule

module seg_digit_driver #(
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sel,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        pending,
  output logic        err
);
  localparam int unsigned NUM_DIG = 4;
  localparam bit          NO_BLANK = (BLANK_CYC == 0);
  localparam logic [CNT_W-1:0] BLANK_LD = NO_BLANK ? '0 : CNT_W'(BLANK_CYC - 1);

  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              pending_q, pending_d;
  logic              err_q, err_d;
  logic [15:0]       disp_q, disp_d;
  logic [15:0]       pend_q, pend_d;
  logic [3:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  blank_cnt_q, blank_cnt_d;

  logic                            sel_chg, sel_ok;
  logic [NUM_DIG-1:0]              lz_blank;
  logic [NUM_DIG-1:0][6:0]         glyph;
  logic [6:0]                      glyph_pick;

  assign sel_chg = (sel != sel_q);
  assign sel_ok  = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);

  // Glyphs come from disp_d so a commit on the sampling edge is visible when there is no dead time
  for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
`ifdef SEG_LZ_BLANK_EN
    if (k == 0) begin : g_d0
      assign lz_blank[k] = 1'b0;
    end else begin : g_dk
      assign lz_blank[k] = (disp_d[15:4*k] == '0);
    end
`else
    assign lz_blank[k] = 1'b0;
`endif
    seg_hex7 u_hex (
      .nib   (disp_d[4*k +: 4]),
      .blank (lz_blank[k]),
      .seg   (glyph[k])
    );
  end

  always_comb begin
    glyph_pick = 7'b1111111;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (sel[k]) glyph_pick = glyph[k];
    end
  end

  always_comb begin
    pend_d      = pend_q;
    pending_d   = pending_q;
    disp_d      = disp_q;
    sel_d       = sel_q;
    blank_cnt_d = blank_cnt_q;
    err_d       = err_q;
    an_d        = 4'b1111;
    seg_d       = 7'b1111111;

    if (sel_chg) begin
      sel_d       = sel;
      blank_cnt_d = BLANK_LD;
      // Frame boundary: rotator has just wrapped back to digit3
      if (sel == 4'b1000 && pending_q) begin
        disp_d    = pend_q;
        pending_d = 1'b0;
      end
    end else if (blank_cnt_q != '0) begin
      blank_cnt_d = blank_cnt_q - 1'b1;
    end

    if (load) begin
      pend_d    = value;
      pending_d = 1'b1;
    end

    if (!sel_ok) begin
      err_d = 1'b1;
    end else if ((sel_chg && NO_BLANK) || (!sel_chg && blank_cnt_q == '0)) begin
      an_d  = ~sel;
      seg_d = glyph_pick;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
      disp_q      <= 16'h0000;
      pend_q      <= 16'h0000;
      sel_q       <= 4'b0000;
      blank_cnt_q <= '0;
    end else begin
      an_q        <= an_d;
      seg_q       <= seg_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      sel_q       <= sel_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign pending = pending_q;
  assign err     = err_q;
endmodule

// File: tb/tb_seg_digit_driver.sv
// Scoreboard bench for seg_digit_driver: a cycle model queues expected outputs, checked after each edge.

module tb_seg_digit_driver;
  localparam int BLANK = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic        load;
  logic [15:0] value;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        pending;
  logic        err;

  seg_digit_driver #(.BLANK_CYC(BLANK), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .sel(sel), .load(load), .value(value),
    .an(an), .seg(seg), .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] ZERO_LEAD = 7'b1111111;
`else
  localparam logic [6:0] ZERO_LEAD = 7'b1000000;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [12:0] exp_q [$];

  // model state
  int          m_off;
  logic [3:0]  m_selq;
  logic [15:0] m_disp, m_pend;
  bit          m_pending, m_err;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input bit r, input logic [3:0] s, input bit ld, input logic [15:0] v);
    logic [3:0]  ean;
    logic [6:0]  eseg;
    logic [12:0] got, expv;
    bit          chg, blanked;
    int          d;
    rst = r; sel = s; load = ld; value = v;
    ean = 4'b1111; eseg = 7'b1111111;
    if (r) begin
      m_off = 0; m_selq = 4'b0000; m_disp = 16'h0; m_pend = 16'h0;
      m_pending = 0; m_err = 0;
    end else begin
      chg = (s != m_selq);
      if (chg) begin
        m_selq = s;
        m_off  = BLANK;
        if (s == 4'b1000 && m_pending) begin
          m_disp = m_pend;
          m_pending = 0;
        end
      end
      if (ld) begin
        m_pend = v;
        m_pending = 1;
      end
      blanked = (m_off > 0);
      if (m_off > 0) m_off--;
      if ($countones(s) != 1) m_err = 1;
      else if (!blanked) begin
        d = 0;
        for (int k = 0; k < 4; k++) if (s[k]) d = k;
        ean  = ~s;
        eseg = hex_tab[(m_disp >> (4 * d)) & 16'hF];
`ifdef SEG_LZ_BLANK_EN
        if (d > 0 && (m_disp >> (4 * d)) == 16'h0) eseg = 7'b1111111;
`endif
      end
    end
    exp_q.push_back({ean, eseg, m_pending, m_err});
    @(posedge clk);
    #1;
    got  = {an, seg, pending, err};
    expv = exp_q.pop_front();
    chk("cycle", {3'b0, got}, {3'b0, expv});
  endtask

  task automatic hold(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) step(0, s, 0, 16'h0);
  endtask

  // Walk 0001/0010/0100 with n cycles each, leaving sel about to return to 1000
  task automatic rotate_lo(input int n);
    hold(4'b0001, n); hold(4'b0010, n); hold(4'b0100, n);
  endtask

  initial begin
    int cur, len;
    logic [3:0] rs;
    rst = 1; sel = 4'b1000; load = 0; value = 16'h0;

    step(1, 4'b1000, 1, 16'hFFFF);
    step(1, 4'b1000, 0, 16'h0);
    chk("rst_an", {12'h0, an}, 16'hF);
    chk("rst_seg", {9'h0, seg}, 16'h7F);
    chk("rst_pending", {15'h0, pending}, 16'h0);

    hold(4'b1000, BLANK);
    chk("blank_last", {12'h0, an}, 16'hF);
    step(0, 4'b1000, 0, 16'h0);
    chk("first_an", {12'h0, an}, 16'h7);
    chk("first_seg", {9'h0, seg}, {9'h0, ZERO_LEAD});

    // commit only at frame boundary
    step(0, 4'b1000, 1, 16'h1A2F);
    rotate_lo(20);
    chk("pend_held", {15'h0, pending}, 16'h1);
    hold(4'b1000, 20);
    chk("pend_clr", {15'h0, pending}, 16'h0);
    chk("d3_1", {9'h0, seg}, 16'b1111001);
    hold(4'b0001, 20); chk("d0_F", {9'h0, seg}, 16'b0001110);
    hold(4'b0010, 20); chk("d1_2", {9'h0, seg}, 16'b0100100);
    hold(4'b0100, 20); chk("d2_A", {9'h0, seg}, 16'b0001000);
    chk("d2_an", {12'h0, an}, 16'b1011);

    // last load wins
    hold(4'b1000, 20);
    step(0, 4'b1000, 1, 16'h1111);
    hold(4'b0001, 20);
    step(0, 4'b0010, 1, 16'h2222);
    hold(4'b0010, 19); hold(4'b0100, 20); hold(4'b1000, 20);
    chk("last_wins", {9'h0, seg}, 16'b0100100);

    // load on the commit edge
    step(0, 4'b0001, 1, 16'h3333);
    hold(4'b0001, 19); hold(4'b0010, 20); hold(4'b0100, 20);
    step(0, 4'b1000, 1, 16'h4444);
    chk("coinc_pend", {15'h0, pending}, 16'h1);
    hold(4'b1000, 20);
    chk("coinc_old", {9'h0, seg}, 16'b0110000);
    rotate_lo(20);
    hold(4'b1000, 20);
    chk("coinc_new", {9'h0, seg}, 16'b0011001);
    chk("coinc_done", {15'h0, pending}, 16'h0);

    // invalid select
    hold(4'b0001, 20);
    step(0, 4'b0110, 0, 16'h0);
    chk("inv_err", {15'h0, err}, 16'h1);
    chk("inv_an", {12'h0, an}, 16'hF);
    hold(4'b0010, 20);
    chk("err_sticky", {15'h0, err}, 16'h1);
    chk("recover_an", {12'h0, an}, 16'b1101);
    step(1, 4'b0010, 0, 16'h0);
    chk("err_clr", {15'h0, err}, 16'h0);

    // leading zeros
    hold(4'b1000, 20);
    step(0, 4'b1000, 1, 16'h0042);
    rotate_lo(20);
    hold(4'b1000, 20); chk("lz_d3", {9'h0, seg}, {9'h0, ZERO_LEAD});
    step(0, 4'b0001, 1, 16'h0000);
    hold(4'b0001, 19); chk("lz_d0", {9'h0, seg}, 16'b0100100);
    hold(4'b0010, 20); chk("lz_d1", {9'h0, seg}, 16'b0011001);
    hold(4'b0100, 20); chk("lz_d2", {9'h0, seg}, {9'h0, ZERO_LEAD});
    hold(4'b1000, 20); rotate_lo(20);
    chk("z_d2", {9'h0, seg}, {9'h0, ZERO_LEAD});
    hold(4'b0001, 20);
    chk("z_d0", {9'h0, seg}, 16'b1000000);

    // random rotation with short holds, glitches, loads and resets
    cur = 0;
    for (int i = 0; i < 120; i++) begin
      len = $urandom_range(1, 24);
      rs  = 4'b1000 >> cur;
      if ($urandom_range(0, 19) == 0) rs = 4'($urandom_range(0, 15));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 199) == 0) step(1, rs, 1, 16'($urandom));
        else step(0, rs, ($urandom_range(0, 9) == 0), 16'($urandom));
      end
      cur = (cur == 0) ? 3 : cur - 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_digit_driver.md
Name: seg_digit_driver

Overview:
- Downstream consumer of the 4-bit one-hot digit rotator (sequence 1000 -> 0001 -> 0010 -> 0100 -> 1000).
- Holds a 16-bit hex value and drives the 4-digit seven-segment display.
- Outputs are active-low anode enables and active-low cathode segments.
- Adds anti-ghosting dead time on every digit switch, and tear-free value updates committed only at a frame boundary.

Parameters:
- BLANK_CYC, default 16: number of clk cycles all anodes are held off after each sampled change of sel. Legal range 0..2^CNT_W-1.
- CNT_W, default 5: width of the dead-time counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- sel  input  4  one-hot digit select from the rotator; 1000=digit3 (value[15:12]), 0100=digit2 ([11:8]), 0010=digit1 ([7:4]), 0001=digit0 ([3:0]).
- load  input  1  single-cycle strobe; captures value into the pending register.
- value  input  16  hex value to display, sampled when load=1.
- an  output  4  anode enables, active low, registered.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active low, registered.
- pending  output  1  high while a loaded value awaits commit.
- err  output  1  sticky flag: non-one-hot sel was sampled.

Behaviour:
- Reset (rst=1 at posedge)
  - an=4'b1111, seg=7'b1111111, pending=0, err=0.
  - Internal: disp=16'h0000, pend=16'h0000, sel_q=4'b0000, blank_cnt=0.
  - rst dominates load and all other inputs in the same cycle.
- Load
  - load=1 -> pend<=value, pending<=1.
  - A load while pending=1 overwrites pend; only the last value is kept.
- Commit
  - On the edge where sampled sel differs from sel_q and sel==4'b1000, if pending=1 then disp<=pend and pending<=0.
  - Load on the same edge as commit: the old pend commits to disp, the new value goes to pend, and pending stays 1.
- Dead time
  - Any edge with sel!=sel_q: sel_q<=sel; blank_cnt<=BLANK_CYC-1 (if BLANK_CYC>0); an<=4'b1111 on that edge.
  - While blank_cnt!=0: an=4'b1111, seg=7'b1111111, blank_cnt decrements by 1 each edge.
  - Net effect: an is all-off for exactly BLANK_CYC edges, starting with the edge that samples the change.
  - BLANK_CYC=0: an<=~sel on the sampling edge, i.e. 1-cycle latency with no blanking.
- Steady drive
  - When blank_cnt==0, sel is one-hot and no change is sampled: an<=~sel_q, seg<=hex7(nibble of disp selected by sel_q).
- hex7 encoding (active low), standard hex glyphs. Examples:
  - 0=1000000, 1=1111001, 2=0100100, 8=0000000, A=0001000, F=0001110.
- Invalid sel (0000, or more than one bit set, sampled on any edge)
  - an<=4'b1111, seg<=7'b1111111, err<=1.
  - err stays 1 until rst.
  - Dead-time counting still applies when sel later returns to a valid one-hot code.
- Reset mid-frame: all state is cleared and disp returns to 0; the first valid sel after reset counts as a change and is blanked for BLANK_CYC cycles.
- No combinational path from any input to an or seg.

Optional Feature:
- Macro SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression. Digit k (k=3..1) shows seg=7'b1111111 when disp nibbles k..3 are all zero; an is still driven low normally. Digit 0 always shows its glyph, so disp=0 displays a single "0".
- Undefined: all four digits always show their glyphs, e.g. 16'h0042 shows "0042".

Test Plan:
- Reset, BLANK_CYC=16, sel=1000 held -> an=1111 for 16 cycles, then an=0111, seg=1000000 (disp=0).
- load with value=16'h1A2F, then rotate sel 0001/0010/0100/1000 -> no display change until sel returns to 1000; pending stays 1 until that edge. The following frame shows digit3=1111001, digit2=0001000, digit1=0100100, digit0=0001110.
- load 16'h1111, then load 16'h2222 before the frame boundary -> 16'h2222 is displayed; 16'h1111 is never shown.
- load coincident with the sel->1000 edge -> previous pend is committed, new value stays pending (pending=1), and it commits at the next frame boundary.
- sel=0110 for one cycle mid-run -> an=1111 and err=1; err remains 1 after sel returns to valid codes, and clears only on rst.
- With SEG_LZ_BLANK_EN defined, load 16'h0042 -> digits 3 and 2 give seg=1111111; digits 1 and 0 show 4 and 2. Load 16'h0000 -> only digit0 shows 1000000.
